imem_loader: RTL and testbench

Boot-time instruction memory with a byte-stream loader port. A host streams a length header followed by program bytes over a valid/ready byte interface. The block assembles the bytes into 32-bit words and writes them into its word array. It holds the single-cycle core in reset until the load completes, then serves `instr` combinationally from the core's `PC`. It is the writer/filler on the far side of the datapath's `PC` → `instr` fetch interface.

---
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Purpose: boot-time instruction memory filled from a length-prefixed byte stream; holds the core in reset until loaded.
// Latency: a word is readable on instr the cycle after its 4th byte is accepted; instr is combinational from PC.
// Backpressure: in_ready depends only on state; high while loading, low once DONE/ERROR until reload.
//
// Ports: clk/reset_n (async active-low), in_data/in_valid/in_ready byte stream, reload (restart from DONE/ERROR),
//   PC -> instr fetch, core_reset_n/done completion, len_err/chk_err sticky errors, words_loaded word count.
// Optional feature: define IMEM_LOAD_CHECKSUM_EN for a trailing XOR checksum byte with CSUM/ERROR states.
module imem_loader #(
  parameter int depth = 64,
  parameter int aw    = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  input  logic [31:0] PC,
  output logic [31:0] instr,
  output logic        core_reset_n,
  output logic        done,
  output logic        len_err,
  output logic        chk_err,
  output logic [15:0] words_loaded
);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM, ST_DONE, ST_ERROR} state_t;
  // Where the stream goes once the data words are exhausted.
  localparam state_t ST_AFTER_DATA = ST_CSUM;
`else
  typedef enum logic [1:0] {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_DONE} state_t;
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  state_t      state, state_nx;
  logic [15:0] len_q;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic [31:0] mem [depth];

  logic [15:0] len_hdr;
  logic        take;
  logic        restart;
  logic        last_word;
  logic        word_done;
  logic        in_range;
  logic        unused_pc;

  assign len_hdr   = {in_data, len_q[7:0]};
  assign take      = in_valid && in_ready;
  assign last_word = ({1'b0, word_cnt} + 17'd1) == {1'b0, len_q};
  assign word_done = (state == ST_DATA) && take && (byte_cnt == 2'd3);
  // Overflow words (len > depth) are consumed and counted but never written.
  assign in_range  = {1'b0, word_cnt} < 17'(depth);

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0] xor_acc;
  assign restart = ((state == ST_DONE) || (state == ST_ERROR)) && reload;
`else
  assign restart = (state == ST_DONE) && reload;
  assign chk_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (len_hdr == 16'd0) ? ST_AFTER_DATA : ST_DATA;
      end
      ST_DATA: begin
        in_ready = 1'b1;
        if (in_valid && (byte_cnt == 2'd3) && last_word) state_nx = ST_AFTER_DATA;
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      ST_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_data == xor_acc) ? ST_DONE : ST_ERROR;
      end
      ST_ERROR: begin
        if (reload) state_nx = ST_LEN_LO;
      end
`endif
      ST_DONE: begin
        if (reload) state_nx = ST_LEN_LO;
      end
      default: state_nx = ST_LEN_LO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_LEN_LO;
      core_reset_n <= 1'b0;
      done         <= 1'b0;
      len_err      <= 1'b0;
      len_q        <= 16'd0;
      word_cnt     <= 16'd0;
      byte_cnt     <= 2'd0;
      shift        <= 24'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      chk_err      <= 1'b0;
      xor_acc      <= 8'd0;
`endif
    end else begin
      state <= state_nx;
      // Both completion outputs are registered views of "entering DONE".
      core_reset_n <= (state_nx == ST_DONE);
      done         <= (state_nx == ST_DONE);
      if (restart) begin
        len_err  <= 1'b0;
        word_cnt <= 16'd0;
        byte_cnt <= 2'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        chk_err  <= 1'b0;
        xor_acc  <= 8'd0;
`endif
      end else if (take) begin
        case (state)
          ST_LEN_LO: len_q[7:0] <= in_data;
          ST_LEN_HI: begin
            len_q[15:8] <= in_data;
            if ({1'b0, len_hdr} > 17'(depth)) len_err <= 1'b1;
          end
          ST_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {in_data, shift[23:8]};
            if (byte_cnt == 2'd3) word_cnt <= word_cnt + 16'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            xor_acc  <= xor_acc ^ in_data;
`endif
          end
`ifdef IMEM_LOAD_CHECKSUM_EN
          ST_CSUM: if (in_data != xor_acc) chk_err <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  // Array has no reset so its contents survive reset_n and reload.
  always_ff @(posedge clk) begin
    if (word_done && in_range) mem[word_cnt[aw-1:0]] <= {in_data, shift};
  end

  assign instr        = mem[PC[aw+1:2]];
  assign words_loaded = word_cnt;
  assign unused_pc    = ^{PC[31:aw+2], PC[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: self-checking bench for imem_loader (depth 4) with a stream-level reference model.
// Latency: model memory updates on the accepting edge; outputs compared on every falling edge.
// Backpressure: driver presents bytes with and without idle gaps; model decides acceptance itself.
module tb_imem_loader;
  localparam int DEPTH = 4;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic [31:0] PC = 32'd0;
  logic [31:0] instr;
  logic        core_reset_n, done, len_err, chk_err;
  logic [15:0] words_loaded;

  imem_loader #(.depth(DEPTH), .aw(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .PC(PC), .instr(instr),
    .core_reset_n(core_reset_n), .done(done), .len_err(len_err),
    .chk_err(chk_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit tb_done  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: bytes accepted since load start ----------------
  logic [7:0]  bq[$];
  logic [31:0] exp_mem[DEPTH];
  bit          exp_known[DEPTH];

  function automatic int m_len();
    if (bq.size() < 2) return 0;
    return int'({bq[1], bq[0]});
  endfunction

  function automatic bit m_complete();
    return (bq.size() >= 2) && (bq.size() == 2 + 4 * m_len() + CSUM);
  endfunction

  function automatic bit m_csum_ok();
    logic [7:0] x = 8'h00;
    if (CSUM == 0) return 1'b1;
    for (int i = 2; i < bq.size() - 1; i++) x ^= bq[i];
    return x == bq[bq.size() - 1];
  endfunction

  function automatic int m_words();
    int d;
    if (bq.size() < 2) return 0;
    d = bq.size() - 2;
    if (d > 4 * m_len()) d = 4 * m_len();
    return d / 4;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bq.delete();
    end else if (m_complete()) begin
      if (reload) bq.delete();
    end else if (in_valid) begin
      int n, k;
      bq.push_back(in_data);
      n = bq.size();
      if (n >= 6 && ((n - 2) % 4) == 0 && ((n - 2) / 4) <= m_len()) begin
        k = (n - 2) / 4 - 1;
        if (k < DEPTH) begin
          exp_mem[k]   = {bq[n-1], bq[n-2], bq[n-3], bq[n-4]};
          exp_known[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!tb_done) begin
      bit fin_ok, fin_bad;
      fin_ok  = m_complete() && m_csum_ok();
      fin_bad = m_complete() && !m_csum_ok();
      check("in_ready", {31'd0, in_ready}, {31'd0, !m_complete()});
      check("done", {31'd0, done}, {31'd0, fin_ok});
      check("core_reset_n", {31'd0, core_reset_n}, {31'd0, fin_ok});
      check("len_err", {31'd0, len_err}, {31'd0, (bq.size() >= 2) && (m_len() > DEPTH)});
      check("chk_err", {31'd0, chk_err}, {31'd0, fin_bad});
      check("words_loaded", {16'd0, words_loaded}, m_words());
      if (exp_known[PC[3:2]]) check("instr", instr, exp_mem[PC[3:2]]);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] b, input bit gap);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gap);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < s.size(); i++) begin
      send(s[i], gap);
      if (i >= 2) x ^= s[i];
    end
    if (CSUM != 0) send(x, gap);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic pc_check(input string name, input logic [31:0] pc, input logic [31:0] exp);
    PC = pc;
    #1;
    check(name, instr, exp);
  endtask

  initial begin
    logic [7:0] s[$];

    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Two-word load, continuous valid
    s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(s, 1'b0);
    check("a_done_edge", {31'd0, done}, 32'd1);
    check("a_core_rst_edge", {31'd0, core_reset_n}, 32'd1);
    check("a_words", {16'd0, words_loaded}, 32'd2);
    pc_check("a_pc4", 32'd4, 32'hDDCCBBAA);
    pc_check("a_pc0", 32'd0, 32'h44332211);
    pc_check("a_pc_wrap", 32'hFFFF_FFF7, 32'hDDCCBBAA);

    // Reload and repeat with idle gaps between bytes
    pulse_reload();
    check("b_core_rst_fall", {31'd0, core_reset_n}, 32'd0);
    check("b_in_ready", {31'd0, in_ready}, 32'd1);
    send_stream(s, 1'b1);
    check("b_done", {31'd0, done}, 32'd1);
    pc_check("b_pc0", 32'd0, 32'h44332211);
    pc_check("b_pc4", 32'd4, 32'hDDCCBBAA);

    // Overlong header: 6 words into a 4-word array
    pulse_reload();
    send(8'h06, 1'b0);
    send(8'h00, 1'b0);
    check("c_len_err", {31'd0, len_err}, 32'd1);
    s = {};
    for (int i = 0; i < 24; i++) s.push_back(8'(8'h10 + i));
    begin
      logic [7:0] x = 8'h00;
      for (int i = 0; i < 24; i++) begin
        send(s[i], 1'b0);
        x ^= s[i];
      end
      if (CSUM != 0) send(x, 1'b0);
    end
    check("c_done", {31'd0, done}, 32'd1);
    check("c_words", {16'd0, words_loaded}, 32'd6);
    pc_check("c_pc0", 32'd0, 32'h13121110);
    pc_check("c_pc12", 32'd12, 32'h1F1E1D1C);

    // Zero-length load leaves memory alone
    pulse_reload();
    s = '{8'h00, 8'h00};
    send_stream(s, 1'b0);
    check("d_done", {31'd0, done}, 32'd1);
    check("d_len_err", {31'd0, len_err}, 32'd0);
    pc_check("d_pc12", 32'd12, 32'h1F1E1D1C);
    pulse_reload();

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Bad checksum: XOR of 01 02 03 04 is 04, send 05
    s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < s.size(); i++) send(s[i], 1'b0);
    check("e_chk_err", {31'd0, chk_err}, 32'd1);
    check("e_core_rst", {31'd0, core_reset_n}, 32'd0);
    check("e_done", {31'd0, done}, 32'd0);
    check("e_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_reload();
    check("e_chk_clr", {31'd0, chk_err}, 32'd0);
    check("e_ready_again", {31'd0, in_ready}, 32'd1);
`endif

    // Reset mid-load after two data bytes
    s = '{8'h02, 8'h00, 8'h55, 8'h66};
    for (int i = 0; i < s.size(); i++) send(s[i], 1'b0);
    reset_n = 1'b0;
    #1;
    check("f_in_ready", {31'd0, in_ready}, 32'd1);
    check("f_core_rst", {31'd0, core_reset_n}, 32'd0);
    check("f_words", {16'd0, words_loaded}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_stream(s, 1'b0);
    check("f_done", {31'd0, done}, 32'd1);
    pc_check("f_pc0", 32'd0, 32'h04030201);
    pc_check("f_pc4_kept", 32'd4, 32'h17161514);

    // PC sweep with misaligned low bits and junk high bits
    for (int i = 0; i < 16; i++) begin
      PC = (32'(i) << 2) | (32'(i) & 32'd3) | (32'(i) << 12);
      @(posedge clk); #1;
    end

    tb_done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
